mem_port_arbiter: RTL and testbench

//  Shares one single-ported, variable-latency backing memory between three requesters: the MEM

---
 rtl/mem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory between the data (D), fetch (I) and debug (S) ports.
// Fixed priority D > I > S with starvation promotion, and a watchdog that aborts stuck accesses.
module mem_port_arbiter #(
    parameter int              AW         = 32,
    parameter int              DW         = 32,
    parameter int              STARVE_MAX = 4,
    parameter int              TIMEOUT    = 255,
    parameter logic [DW-1:0]   ERR_DATA   = 32'hDEADBEEF
) (
    input  logic          clk_i,
    input  logic          rst_ni,

    input  logic          dReq_i,
    input  logic          dWe_i,
    input  logic [AW-1:0] dAddr_i,
    input  logic [DW-1:0] dWdata_i,
    output logic          dDone_o,
    output logic [DW-1:0] dRdata_o,

    input  logic          iReq_i,
    input  logic          iWe_i,
    input  logic [AW-1:0] iAddr_i,
    input  logic [DW-1:0] iWdata_i,
    output logic          iDone_o,
    output logic [DW-1:0] iRdata_o,

    input  logic          sReq_i,
    input  logic          sWe_i,
    input  logic [AW-1:0] sAddr_i,
    input  logic [DW-1:0] sWdata_i,
    output logic          sDone_o,
    output logic [DW-1:0] sRdata_o,

    output logic          memReq_o,
    output logic          memWe_o,
    output logic [AW-1:0] memAddr_o,
    output logic [DW-1:0] memWdata_o,
    input  logic [DW-1:0] memRdata_i,
    input  logic          memReady_i,

    output logic [1:0]    owner_o,
    output logic          err_o
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] OWN_D    = 2'd0;
    localparam logic [1:0] OWN_I    = 2'd1;
    localparam logic [1:0] OWN_S    = 2'd2;
    localparam logic [1:0] OWN_NONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic          memReq_q, memReq_d;
    logic          memWe_q, memWe_d;
    logic [AW-1:0] memAddr_q, memAddr_d;
    logic [DW-1:0] memWdata_q, memWdata_d;
    logic [DW-1:0] dRdata_q, dRdata_d;
    logic [DW-1:0] iRdata_q, iRdata_d;
    logic [DW-1:0] sRdata_q, sRdata_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          abort_q, abort_d;
    logic [SW-1:0] starveI_q, starveI_d;
    logic [SW-1:0] starveS_q, starveS_d;

    logic [1:0]    winner;
    logic          grant;
    logic          tmoHit;
    logic          finish;
    logic          selWe;
    logic [AW-1:0] selAddr;
    logic [DW-1:0] selWdata;
    logic [DW-1:0] capData;

    // A promoted port only wins while it is still requesting; a dropped request is never granted.
    always_comb begin
        winner = OWN_NONE;
        if (iReq_i && (starveI_q == SW'(STARVE_MAX))) begin
            winner = OWN_I;
        end else if (sReq_i && (starveS_q == SW'(STARVE_MAX))) begin
            winner = OWN_S;
        end else if (dReq_i) begin
            winner = OWN_D;
        end else if (iReq_i) begin
            winner = OWN_I;
        end else if (sReq_i) begin
            winner = OWN_S;
        end
    end

    assign grant  = (state_q == IDLE) && (winner != OWN_NONE);
    assign tmoHit = (state_q == BUSY) && (tmo_q == TW'(TIMEOUT - 1));
    assign finish = (state_q == BUSY) && (memReady_i || tmoHit);

    always_comb begin
        selWe    = 1'b0;
        selAddr  = '0;
        selWdata = '0;
        case (winner)
            OWN_D: begin
                selWe    = dWe_i;
                selAddr  = dAddr_i;
                selWdata = dWdata_i;
            end
            OWN_I: begin
                selWe    = iWe_i;
                selAddr  = iAddr_i;
                selWdata = iWdata_i;
            end
            OWN_S: begin
                selWe    = sWe_i;
                selAddr  = sAddr_i;
                selWdata = sWdata_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = BUSY;
            BUSY:    if (finish) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dDone_o = 1'b0;
        iDone_o = 1'b0;
        sDone_o = 1'b0;
        err_o   = 1'b0;
        if (state_q == DONE) begin
            dDone_o = (owner_q == OWN_D);
            iDone_o = (owner_q == OWN_I);
            sDone_o = (owner_q == OWN_S);
            err_o   = abort_q;
        end
    end

    // mem_ready takes precedence over the watchdog when both land in the same cycle.
    assign capData = memReady_i ? memRdata_i : ERR_DATA;

    always_comb begin
        owner_d    = owner_q;
        memReq_d   = memReq_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        dRdata_d   = dRdata_q;
        iRdata_d   = iRdata_q;
        sRdata_d   = sRdata_q;
        tmo_d      = tmo_q;
        abort_d    = abort_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d    = winner;
                    memReq_d   = 1'b1;
                    memWe_d    = selWe;
                    memAddr_d  = selAddr;
                    memWdata_d = selWdata;
                    tmo_d      = '0;
                    abort_d    = 1'b0;
                end else begin
                    owner_d = OWN_NONE;
                end
            end
            BUSY: begin
                tmo_d = tmo_q + TW'(1);
                if (finish) begin
                    memReq_d = 1'b0;
                    abort_d  = !memReady_i;
                    case (owner_q)
                        OWN_D:   dRdata_d = capData;
                        OWN_I:   iRdata_d = capData;
                        OWN_S:   sRdata_d = capData;
                        default: ;
                    endcase
                end
            end
            DONE: begin
                owner_d = OWN_NONE;
            end
            default: ;
        endcase
    end

    // Starvation counts only advance on an actual lost arbitration and reset whenever req drops.
    always_comb begin
        starveI_d = starveI_q;
        starveS_d = starveS_q;
        if (!iReq_i) begin
            starveI_d = '0;
        end else if (grant) begin
            if (winner == OWN_I) begin
                starveI_d = '0;
            end else if (starveI_q != SW'(STARVE_MAX)) begin
                starveI_d = starveI_q + SW'(1);
            end
        end
        if (!sReq_i) begin
            starveS_d = '0;
        end else if (grant) begin
            if (winner == OWN_S) begin
                starveS_d = '0;
            end else if (starveS_q != SW'(STARVE_MAX)) begin
                starveS_d = starveS_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q    <= OWN_NONE;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            dRdata_q   <= '0;
            iRdata_q   <= '0;
            sRdata_q   <= '0;
            tmo_q      <= '0;
            abort_q    <= 1'b0;
            starveI_q  <= '0;
            starveS_q  <= '0;
        end else begin
            owner_q    <= owner_d;
            memReq_q   <= memReq_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            dRdata_q   <= dRdata_d;
            iRdata_q   <= iRdata_d;
            sRdata_q   <= sRdata_d;
            tmo_q      <= tmo_d;
            abort_q    <= abort_d;
            starveI_q  <= starveI_d;
            starveS_q  <= starveS_d;
        end
    end

    assign owner_o    = owner_q;
    assign memReq_o   = memReq_q;
    assign memWe_o    = memWe_q;
    assign memAddr_o  = memAddr_q;
    assign memWdata_o = memWdata_q;
    assign dRdata_o   = dRdata_q;
    assign iRdata_o   = iRdata_q;
    assign sRdata_o   = sRdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, latency, priority, starvation, timeout and stray ready.
// Inputs change and outputs are checked 1ns after each rising edge.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rstN;
    logic        dReq, iReq, sReq;
    logic        dWe, iWe, sWe;
    logic [31:0] dAddr, iAddr, sAddr;
    logic [31:0] dWdata, iWdata, sWdata;
    logic        dDone, iDone, sDone;
    logic [31:0] dRdata, iRdata, sRdata;
    logic        memReq, memWe, memReady;
    logic [31:0] memAddr, memWdata, memRdata;
    logic [1:0]  owner;
    logic        err;

    int compared   = 0;
    int mismatched = 0;

    logic [2:0] doneTab  [10] = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000,
                                  3'b010, 3'b000, 3'b000, 3'b100, 3'b000};
    logic [1:0] ownerTab [10] = '{2'd3, 2'd0, 2'd0, 2'd3, 2'd1,
                                  2'd1, 2'd3, 2'd2, 2'd2, 2'd3};

    mem_port_arbiter #(
        .AW(32), .DW(32), .STARVE_MAX(4), .TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .clk_i(clk), .rst_ni(rstN),
        .dReq_i(dReq), .dWe_i(dWe), .dAddr_i(dAddr), .dWdata_i(dWdata),
        .dDone_o(dDone), .dRdata_o(dRdata),
        .iReq_i(iReq), .iWe_i(iWe), .iAddr_i(iAddr), .iWdata_i(iWdata),
        .iDone_o(iDone), .iRdata_o(iRdata),
        .sReq_i(sReq), .sWe_i(sWe), .sAddr_i(sAddr), .sWdata_i(sWdata),
        .sDone_o(sDone), .sRdata_o(sRdata),
        .memReq_o(memReq), .memWe_o(memWe), .memAddr_o(memAddr), .memWdata_o(memWdata),
        .memRdata_i(memRdata), .memReady_i(memReady),
        .owner_o(owner), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    initial begin
        int dCount;
        rstN = 1'b0;
        dReq = 0; iReq = 0; sReq = 0;
        dWe = 0; iWe = 0; sWe = 0;
        dAddr = 0; iAddr = 0; sAddr = 0;
        dWdata = 0; iWdata = 0; sWdata = 0;
        memReady = 0; memRdata = 0;

        // Reset values and reset abandoning a BUSY access
        #12;
        checkOutput("rst_memReq", 32'(memReq), 32'd0);
        checkOutput("rst_owner", 32'(owner), 32'd3);
        checkOutput("rst_done", 32'({sDone, iDone, dDone}), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_memAddr", memAddr, 32'd0);
        checkOutput("rst_dRdata", dRdata, 32'd0);
        applyStimulus(1);
        rstN = 1'b1;
        dReq = 1; dWe = 0; dAddr = 32'h40;
        applyStimulus(1);
        checkOutput("r1_busy_memReq", 32'(memReq), 32'd1);
        checkOutput("r1_busy_owner", 32'(owner), 32'd0);
        rstN = 1'b0;
        #1;
        checkOutput("r1_mid_memReq", 32'(memReq), 32'd0);
        checkOutput("r1_mid_owner", 32'(owner), 32'd3);
        applyStimulus(1);
        checkOutput("r1_nodone", 32'(dDone), 32'd0);
        rstN = 1'b1;
        applyStimulus(1);
        checkOutput("r1_regrant_owner", 32'(owner), 32'd0);
        checkOutput("r1_regrant_addr", memAddr, 32'h40);
        memReady = 1; memRdata = 32'hA5A50001;
        applyStimulus(1);
        memReady = 0;
        checkOutput("r1_dDone", 32'(dDone), 32'd1);
        checkOutput("r1_dRdata", dRdata, 32'hA5A50001);
        dReq = 0;
        applyStimulus(1);
        checkOutput("r1_idle_owner", 32'(owner), 32'd3);
        checkOutput("r1_dDone_low", 32'(dDone), 32'd0);

        // Single read with two wait cycles
        iReq = 1; iWe = 0; iAddr = 32'h100;
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(1);
            checkOutput($sformatf("rd_memReq_c%0d", c), 32'(memReq), 32'd1);
            checkOutput($sformatf("rd_iDone_c%0d", c), 32'(iDone), 32'd0);
        end
        checkOutput("rd_memAddr", memAddr, 32'h100);
        checkOutput("rd_memWe", 32'(memWe), 32'd0);
        memReady = 1; memRdata = 32'h12345678;
        applyStimulus(1);
        memReady = 0;
        checkOutput("rd_iDone_c4", 32'(iDone), 32'd1);
        checkOutput("rd_iRdata", iRdata, 32'h12345678);
        checkOutput("rd_memReq_c4", 32'(memReq), 32'd0);
        iReq = 0;
        applyStimulus(1);
        checkOutput("rd_iDone_c5", 32'(iDone), 32'd0);
        checkOutput("rd_owner_c5", 32'(owner), 32'd3);

        // Three simultaneous reads on zero-wait memory
        dReq = 1; dWe = 0; dAddr = 32'h10;
        iReq = 1; iAddr = 32'h20;
        sReq = 1; sWe = 0; sAddr = 32'h30;
        memReady = 1; memRdata = 32'h30000000;
        for (int c = 1; c <= 9; c++) begin
            applyStimulus(1);
            memRdata = 32'h30000000 + 32'(c);
            checkOutput($sformatf("pri_done_c%0d", c), 32'({sDone, iDone, dDone}), 32'(doneTab[c]));
            checkOutput($sformatf("pri_owner_c%0d", c), 32'(owner), 32'(ownerTab[c]));
            if (c == 1) checkOutput("pri_addr_d", memAddr, 32'h10);
            if (c == 4) checkOutput("pri_addr_i", memAddr, 32'h20);
            if (c == 7) checkOutput("pri_addr_s", memAddr, 32'h30);
            if (c == 2) checkOutput("pri_dRdata", dRdata, 32'h30000001);
            if (c == 5) checkOutput("pri_iRdata", iRdata, 32'h30000004);
            if (c == 8) checkOutput("pri_sRdata", sRdata, 32'h30000007);
            if (doneTab[c][0]) dReq = 0;
            if (doneTab[c][1]) iReq = 0;
            if (doneTab[c][2]) sReq = 0;
        end

        // Starvation promotion: D streams six writes while I waits
        dCount = 0;
        dReq = 1; dWe = 1; dAddr = 32'h1000; dWdata = 32'hD0D0D0D0;
        iReq = 1; iAddr = 32'h200;
        memRdata = 32'h44440000;
        for (int c = 1; c <= 21; c++) begin
            applyStimulus(1);
            if (c % 3 == 1) begin
                checkOutput($sformatf("stv_owner_c%0d", c), 32'(owner), (c == 13) ? 32'd1 : 32'd0);
                checkOutput($sformatf("stv_we_c%0d", c), 32'(memWe), (c == 13) ? 32'd0 : 32'd1);
                checkOutput($sformatf("stv_addr_c%0d", c), memAddr, (c == 13) ? 32'h200 : dAddr);
            end
            if (c % 3 == 2) begin
                checkOutput($sformatf("stv_done_c%0d", c), 32'({sDone, iDone, dDone}),
                            (c == 14) ? 32'b010 : 32'b001);
                if (c == 14) begin
                    iReq = 0;
                end else begin
                    dCount++;
                    if (dCount == 6) dReq = 0;
                    else dAddr = 32'h1000 + 32'(4 * dCount);
                end
            end
        end
        memReady = 0;

        // Watchdog abort with no mem_ready
        sReq = 1; sWe = 0; sAddr = 32'h300;
        for (int c = 1; c <= 8; c++) begin
            applyStimulus(1);
            checkOutput($sformatf("tmo_memReq_c%0d", c), 32'(memReq), 32'd1);
            checkOutput($sformatf("tmo_sDone_c%0d", c), 32'(sDone), 32'd0);
        end
        applyStimulus(1);
        checkOutput("tmo_memReq_drop", 32'(memReq), 32'd0);
        checkOutput("tmo_sDone", 32'(sDone), 32'd1);
        checkOutput("tmo_err", 32'(err), 32'd1);
        checkOutput("tmo_sRdata", sRdata, 32'hDEADBEEF);
        sReq = 0;
        applyStimulus(1);
        checkOutput("tmo_err_low", 32'(err), 32'd0);
        checkOutput("tmo_owner_idle", 32'(owner), 32'd3);

        // Stray ready in IDLE, then ready exactly on the watchdog cycle
        memReady = 1; memRdata = 32'h55555555;
        applyStimulus(1);
        memReady = 0;
        checkOutput("stray_memReq", 32'(memReq), 32'd0);
        checkOutput("stray_done", 32'({sDone, iDone, dDone}), 32'd0);
        checkOutput("stray_iRdata", iRdata, 32'h44440000);
        checkOutput("stray_dRdata", dRdata, 32'h44440000);
        iReq = 1; iAddr = 32'h400;
        for (int c = 1; c <= 8; c++) begin
            applyStimulus(1);
            checkOutput($sformatf("edge_memReq_c%0d", c), 32'(memReq), 32'd1);
            if (c == 8) begin
                memReady = 1; memRdata = 32'h600D600D;
            end
        end
        applyStimulus(1);
        memReady = 0;
        checkOutput("edge_iDone", 32'(iDone), 32'd1);
        checkOutput("edge_err", 32'(err), 32'd0);
        checkOutput("edge_iRdata", iRdata, 32'h600D600D);
        checkOutput("edge_sRdata_kept", sRdata, 32'hDEADBEEF);
        iReq = 0;
        applyStimulus(1);
        checkOutput("edge_owner_idle", 32'(owner), 32'd3);
        checkOutput("edge_iDone_low", 32'(iDone), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
